// File: rtl/i2s_codec_master_if.sv
// rtl/i2s_codec_master_if.sv - sample-side valid/ready bundle of the codec-side I2S master
interface i2s_codec_master_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tx_left;
    logic [DATA_WIDTH-1:0] tx_right;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [DATA_WIDTH-1:0] rx_left;
    logic [DATA_WIDTH-1:0] rx_right;
    logic                  rx_valid;

    modport master (
        output tx_left, tx_right, tx_valid,
        input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );

    modport slave (
        input  tx_left, tx_right, tx_valid,
        output tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );
endinterface

// File: rtl/i2s_codec_master.sv
// rtl/i2s_codec_master.sv - codec-side I2S master: BCLK/LRCK generation, ADCDAT serializer, DACDAT deserializer
module i2s_codec_master #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              bclk,
    output logic              lrck,
    output logic              adcdat,
    input  logic              dacdat,
    i2s_codec_master_if.slave smp
);
    localparam int KW = $clog2(2 * SLOT_BITS);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(2 * SLOT_BITS - 1);
    localparam logic [KW-1:0] S_K    = KW'(SLOT_BITS);
    localparam logic [KW-1:0] W_K    = KW'(DATA_WIDTH);
    localparam logic [DW-1:0] D_LAST = DW'(BCLK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic [DW-1:0]         div_q;
    logic [KW-1:0]         k_q;
    logic                  first_q;
    logic                  bclk_q;
    logic                  lrck_q;
    logic                  adcdat_q;
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] hold_left_q;
    logic [DATA_WIDTH-1:0] hold_right_q;
    logic [DATA_WIDTH-1:0] tx_sh_q;
    logic [DATA_WIDTH-1:0] tx_right_q;
    logic                  tx_underrun_q;
    logic [DATA_WIDTH-2:0] rx_sh_q;
    logic [DATA_WIDTH-1:0] rx_stage_q;
    logic [DATA_WIDTH-1:0] rx_left_q;
    logic [DATA_WIDTH-1:0] rx_right_q;
    logic                  rx_valid_q;

    logic                  tick;
    logic                  fall;
    logic                  rise;
    logic [KW-1:0]         k_d;
    logic [KW-1:0]         pos_d;
    logic [KW-1:0]         pos_q;
    logic                  frame_end;
    logic                  load;
    logic                  accept;
    logic                  rx_bit;
    logic [DATA_WIDTH-1:0] rx_word;

    // k_q holds the index of the bit launched at the most recent falling edge
    always_comb begin
        tick      = (state_q == RUN) && (div_q == D_LAST);
        fall      = tick && bclk_q;
        rise      = tick && !bclk_q;
        k_d       = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        pos_d     = (k_d >= S_K) ? k_d - S_K : k_d;
        pos_q     = (k_q >= S_K) ? k_q - S_K : k_q;
        frame_end = fall && (k_q == K_LAST) && !first_q && !enable;
        load      = fall && !frame_end && (k_d == '0);
        accept    = smp.tx_valid && !hold_full_q;
        rx_bit    = rise && (pos_q != '0) && (pos_q <= W_K);
        rx_word   = {rx_sh_q, dacdat};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            div_q         <= '0;
            k_q           <= K_LAST;
            first_q       <= 1'b1;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b1;
            adcdat_q      <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            tx_sh_q       <= '0;
            tx_right_q    <= '0;
            tx_underrun_q <= 1'b0;
            rx_sh_q       <= '0;
            rx_stage_q    <= '0;
            rx_left_q     <= '0;
            rx_right_q    <= '0;
            rx_valid_q    <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            rx_valid_q    <= 1'b0;

            if (accept) begin
                hold_left_q  <= smp.tx_left;
                hold_right_q <= smp.tx_right;
                hold_full_q  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    bclk_q   <= 1'b0;
                    lrck_q   <= 1'b1;
                    adcdat_q <= 1'b0;
                    div_q    <= '0;
                    k_q      <= K_LAST;
                    first_q  <= 1'b1;
                    if (enable) begin
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        bclk_q <= !bclk_q;
                    end

                    if (frame_end) begin
                        state_q  <= IDLE;
                        lrck_q   <= 1'b1;
                        adcdat_q <= 1'b0;
                    end else if (fall) begin
                        k_q     <= k_d;
                        first_q <= 1'b0;
                        lrck_q  <= (k_d >= S_K);
                        // one-BCLK I2S delay: slot position 0 stays low, MSB goes out at position 1
                        if ((pos_d != '0) && (pos_d <= W_K)) begin
                            adcdat_q <= tx_sh_q[DATA_WIDTH-1];
                            tx_sh_q  <= tx_sh_q << 1;
                        end else begin
                            adcdat_q <= 1'b0;
                        end
                        if (load) begin
                            if (hold_full_q) begin
                                tx_sh_q     <= hold_left_q;
                                tx_right_q  <= hold_right_q;
                                hold_full_q <= 1'b0;
                            end else begin
                                tx_sh_q       <= '0;
                                tx_right_q    <= '0;
                                tx_underrun_q <= 1'b1;
                            end
                        end else if (k_d == S_K) begin
                            tx_sh_q <= tx_right_q;
                        end
                    end

                    if (rx_bit) begin
                        rx_sh_q <= rx_word[DATA_WIDTH-2:0];
                        if (pos_q == W_K) begin
                            if (k_q < S_K) begin
                                rx_stage_q <= rx_word;
                            end else begin
                                rx_left_q  <= rx_stage_q;
                                rx_right_q <= rx_word;
                                rx_valid_q <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bclk            = bclk_q;
    assign lrck            = lrck_q;
    assign adcdat          = adcdat_q;
    assign smp.tx_ready    = !hold_full_q;
    assign smp.tx_underrun = tx_underrun_q;
    assign smp.rx_left     = rx_left_q;
    assign smp.rx_right    = rx_right_q;
    assign smp.rx_valid    = rx_valid_q;
endmodule

// File: tb/tb_i2s_codec_master.sv
// tb/tb_i2s_codec_master.sv - loopback bench for i2s_codec_master with frame and rx scoreboards
module tb_i2s_codec_master;
    localparam int FRAME = 4 * 32 * 2;

    logic clk;
    logic reset_n;
    logic enable;
    logic bclk;
    logic lrck;
    logic adcdat;
    wire  dacdat;

    i2s_codec_master_if #(.DATA_WIDTH(16)) bus ();

    assign dacdat = adcdat;

    i2s_codec_master #(
        .DATA_WIDTH(16),
        .SLOT_BITS (32),
        .BCLK_DIV  (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .bclk   (bclk),
        .lrck   (lrck),
        .adcdat (adcdat),
        .dacdat (dacdat),
        .smp    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          bclk_prev = 1'b0;
    bit          lrck_prev = 1'b1;
    bit          in_frame = 1'b0;
    int          mk = 0;
    logic [63:0] cap = '0;
    int          rx_cnt = 0;
    int          last_start = 0;
    bit          model_full = 1'b0;
    logic [15:0] m_l = '0;
    logic [15:0] m_r = '0;
    logic [31:0] frame_q[$];
    logic [31:0] rx_q[$];
    bit          last_acc = 1'b0;
    bit          last_start_flag = 1'b0;
    int          acc_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: sample at negedge, update the reference receiver and holding-register model
    task automatic tick();
        bit          fs;
        bit          fell;
        bit          rose;
        bit          acc;
        bit          exp_und;
        logic [31:0] p;
        logic [63:0] ef;
        @(negedge clk);
        cyc++;
        fell            = bclk_prev && !bclk;
        rose            = !bclk_prev && bclk;
        fs              = fell && lrck_prev && !lrck;
        acc             = bus.tx_valid && !model_full;
        exp_und         = 1'b0;
        last_acc        = acc;
        last_start_flag = fs;
        if (!reset_n) begin
            model_full = 1'b0;
            frame_q.delete();
            rx_q.delete();
            in_frame        = 1'b0;
            rx_cnt          = 0;
            last_acc        = 1'b0;
            last_start_flag = 1'b0;
        end else begin
            if (fs) begin
                if (in_frame && mk == 63) chk("frame_period", 64'(cyc - last_start), 64'(FRAME));
                p          = model_full ? {m_l, m_r} : 32'h0;
                exp_und    = !model_full;
                model_full = 1'b0;
                frame_q.push_back(p);
                rx_q.push_back(p);
                last_start = cyc;
                in_frame   = 1'b1;
                mk         = 0;
                rx_cnt     = 0;
            end else if (fell && in_frame) begin
                if (mk == 63) in_frame = 1'b0;
                else mk++;
            end
            if (acc) begin
                model_full = 1'b1;
                m_l        = bus.tx_left;
                m_r        = bus.tx_right;
                acc_cyc    = cyc;
            end
            if (rose && in_frame) begin
                chk("lrck_slot", 64'(lrck), 64'(mk >= 32));
                cap[63-mk] = adcdat;
                if (mk == 63) begin
                    chk("rx_pulses_per_frame", 64'(rx_cnt), 64'd1);
                    if (frame_q.size() == 0) begin
                        chk("frame_expected", 64'd0, 64'd1);
                    end else begin
                        p  = frame_q.pop_front();
                        ef = (64'(p[31:16]) << 47) | (64'(p[15:0]) << 15);
                        chk("adc_frame", cap, ef);
                    end
                end
            end
            if (bus.rx_valid) begin
                rx_cnt++;
                if (rx_q.size() == 0) begin
                    chk("rx_expected", 64'd0, 64'd1);
                end else begin
                    p = rx_q.pop_front();
                    chk("rx_pair", 64'({bus.rx_left, bus.rx_right}), 64'(p));
                end
            end
        end
        chk("tx_ready", 64'(bus.tx_ready), 64'(!model_full));
        chk("tx_underrun", 64'(bus.tx_underrun), 64'(exp_und));
        bclk_prev = bclk;
        lrck_prev = lrck;
    endtask

    task automatic check_reset_values();
        chk("rst_bclk", 64'(bclk), 64'd0);
        chk("rst_lrck", 64'(lrck), 64'd1);
        chk("rst_adcdat", 64'(adcdat), 64'd0);
        chk("rst_tx_ready", 64'(bus.tx_ready), 64'd1);
        chk("rst_tx_underrun", 64'(bus.tx_underrun), 64'd0);
        chk("rst_rx_left", 64'(bus.rx_left), 64'd0);
        chk("rst_rx_right", 64'(bus.rx_right), 64'd0);
        chk("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
    endtask

    // enable from idle: bclk rises 2 cycles after enable is sampled, falls 2 later with lrck=0
    task automatic start_check();
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("bclk_start", 64'(bclk), 64'(i == 3 || i == 4));
        end
        chk("lrck_start", 64'(lrck), 64'd0);
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r, input bit expect_wait);
        bit got;
        got          = 1'b0;
        bus.tx_left  = l;
        bus.tx_right = r;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            tick();
            got = last_acc;
        end
        bus.tx_valid = 1'b0;
        chk("offer_accepted", 64'(got), 64'd1);
        if (got && expect_wait) chk("accept_after_load", 64'(acc_cyc - last_start), 64'd1);
    endtask

    task automatic wait_start();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            tick();
            got = last_start_flag;
        end
        chk("frame_start_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3 * FRAME && in_frame; i++) tick();
        chk("idle_reached", 64'(in_frame), 64'd0);
        chk("idle_bclk", 64'(bclk), 64'd0);
        chk("idle_lrck", 64'(lrck), 64'd1);
        chk("idle_adcdat", 64'(adcdat), 64'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_left  = '0;
        bus.tx_right = '0;
        repeat (3) tick();
        check_reset_values();
        reset_n = 1'b1;
        tick();

        // serialization + loopback: pair offered while idle, carried by the first frame
        offer(16'hA5C3, 16'h0F0F, 1'b0);
        start_check();

        // underrun frame, then a pair accepted on the very cycle of the underrun load
        wait_start();
        chk("underrun_seen", 64'(bus.tx_underrun), 64'd1);
        repeat (FRAME - 1) tick();
        bus.tx_left  = 16'h1234;
        bus.tx_right = 16'h5678;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        chk("load_cycle_accept", 64'(last_acc), 64'd1);
        chk("load_cycle_start", 64'(last_start_flag), 64'd1);
        chk("load_cycle_underrun", 64'(bus.tx_underrun), 64'd1);

        // backpressure: A waits for 1234/5678 to load, B waits for A
        offer(16'hBEEF, 16'h8001, 1'b1);
        offer(16'h7FFE, 16'hC0DE, 1'b1);
        wait_start();

        // mid-frame reset aborts the frame carrying B
        repeat (60) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_values();
        reset_n = 1'b1;
        start_check();
        offer(16'h0001, 16'h8000, 1'b0);

        // enable drop at k=40: frame completes with its rx pair, then idle
        wait_start();
        for (int i = 0; i < FRAME && mk != 40; i++) tick();
        chk("reached_k40", 64'(mk), 64'd40);
        enable = 1'b0;
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_hold_bclk", 64'({bclk, lrck}), 64'b01);
        end

        // clean restart after idle
        offer(16'hFFFF, 16'h3C3C, 1'b0);
        start_check();
        enable = 1'b0;
        wait_idle();

        chk("frame_q_drained", 64'(frame_q.size()), 64'd0);
        chk("rx_q_drained", 64'(rx_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
